// File: rtl/bgd_mul_fxp_pipe_if.sv
// Operand/result bundle for the pipelined fixed-point multiplier.
// The master drives operands and controls; the slave (the multiplier) returns results.
interface bgd_mul_fxp_pipe_if #(
    parameter int unsigned A_WIDTH = 13,
    parameter int unsigned B_WIDTH = 13,
    parameter int unsigned P_WIDTH = 13
);
    logic                 ce;
    logic [A_WIDTH-1:0]   din0;
    logic [B_WIDTH-1:0]   din1;
    logic                 in_valid;
    logic                 clr_ovf;
    logic [P_WIDTH-1:0]   dout;
    logic                 out_valid;
    logic                 ovf;
    logic [15:0]          ovf_cnt;

    modport master (
        output ce, din0, din1, in_valid, clr_ovf,
        input  dout, out_valid, ovf, ovf_cnt
    );

    modport slave (
        input  ce, din0, din1, in_valid, clr_ovf,
        output dout, out_valid, ovf, ovf_cnt
    );
endinterface

// File: rtl/bgd_mul_fxp_pipe.sv
// Pipelined signed fixed-point multiplier: operand regs, full product, delay regs,
// then round/shift/saturate into the output register. Whole pipe advances on ce.
module bgd_mul_fxp_pipe #(
    parameter int unsigned A_WIDTH   = 13,
    parameter int unsigned B_WIDTH   = 13,
    parameter int unsigned P_WIDTH   = 13,
    parameter int unsigned FRAC_BITS = 6,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned ROUND     = 1,
    parameter int unsigned SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    bgd_mul_fxp_pipe_if.slave    bus
);

    localparam int unsigned PW = A_WIDTH + B_WIDTH;
    // Product register plus the pure delay registers that follow it
    localparam int unsigned NP = NUM_STAGE - 2;
    // Post-product arithmetic width: one guard bit over the product, never narrower than dout
    localparam int unsigned EW = ((PW + 1) > P_WIDTH) ? (PW + 1) : P_WIDTH;
    localparam int unsigned HW = EW - P_WIDTH + 1;
    localparam logic [EW-1:0] RND_K = (ROUND != 0 && FRAC_BITS > 0)
        ? (EW'(1) << ((FRAC_BITS > 0) ? (FRAC_BITS - 1) : 0)) : '0;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [A_WIDTH-1:0] a_q, a_d;
    logic [B_WIDTH-1:0] b_q, b_d;
    logic               v1_q, v1_d;
    logic [PW-1:0]      prod_q [NP];
    logic [PW-1:0]      prod_d [NP];
    logic [NP-1:0]      pv_q, pv_d;
    logic [P_WIDTH-1:0] dout_q, dout_d;
    logic               out_valid_q, out_valid_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        ovf_cnt_q, ovf_cnt_d;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;
    logic [HW-1:0]        hi;
    logic                 ovf_raw;
    logic [P_WIDTH-1:0]   res;

    // Round, shift and range-limit the oldest product in the delay line
    always_comb begin : final_arith
        ext     = '0;
        shifted = '0;
        hi      = '0;
        ovf_raw = 1'b0;
        res     = '0;
        ext     = {{(EW-PW){prod_q[NP-1][PW-1]}}, prod_q[NP-1]} + RND_K;
        shifted = ext >>> FRAC_BITS;
        hi      = shifted[EW-1:P_WIDTH-1];
        ovf_raw = !((&hi) || !(|hi));
        if (SATURATE != 0 && ovf_raw) begin
            res = shifted[EW-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                : {1'b0, {(P_WIDTH-1){1'b1}}};
        end else begin
            res = shifted[P_WIDTH-1:0];
        end
    end

    // Pipeline advance: every stage holds unless ce
    always_comb begin : pipe_next
        a_d         = a_q;
        b_d         = b_q;
        v1_d        = v1_q;
        prod_d      = prod_q;
        pv_d        = pv_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (bus.ce) begin
            a_d         = bus.din0;
            b_d         = bus.din1;
            v1_d        = bus.in_valid;
            prod_d[0]   = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q} *
                          {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};
            pv_d[0]     = v1_q;
            for (int i = 1; i < int'(NP); i++) begin
                prod_d[i] = prod_q[i-1];
                pv_d[i]   = pv_q[i-1];
            end
            dout_d      = res;
            out_valid_d = pv_q[NP-1];
            ovf_d       = pv_q[NP-1] & ovf_raw;
        end
    end

    // Overflow counter: clear wins over increment and ignores ce; sticks at max
    always_comb begin : cnt_next
        ovf_cnt_d = ovf_cnt_q;
        if (bus.clr_ovf) begin
            ovf_cnt_d = '0;
        end else if (bus.ce && pv_q[NP-1] && ovf_raw && ovf_cnt_q != CNT_MAX) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin : regs
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            v1_q        <= 1'b0;
            prod_q      <= '{default: '0};
            pv_q        <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            v1_q        <= v1_d;
            prod_q      <= prod_d;
            pv_q        <= pv_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_bgd_mul_fxp_pipe.sv
// Scoreboard bench: a saturating/rounding instance and a wrapping/truncating instance
// share stimulus; expectations come from integer arithmetic on the operands.
module tb_bgd_mul_fxp_pipe;

    localparam int NS   = 4;
    localparam int FRAC = 6;
    localparam int PWID = 13;
    localparam int PMAX = (1 << (PWID - 1)) - 1;
    localparam int PMIN = -(1 << (PWID - 1));

    typedef struct {
        int idx;
        int d0;
        bit o0;
        int d1;
        bit o1;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ce, in_valid, clr_ovf;
    logic [12:0] din0, din1;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ce_edges = 0;
    int   cnt0_m = 0;
    int   cnt1_m = 0;
    int   prev_d0 = 0, prev_d1 = 0;
    bit   prev_v = 0, prev_o0 = 0, prev_o1 = 0;

    bgd_mul_fxp_pipe_if #(.A_WIDTH(13), .B_WIDTH(13), .P_WIDTH(13)) if0 ();
    bgd_mul_fxp_pipe_if #(.A_WIDTH(13), .B_WIDTH(13), .P_WIDTH(13)) if1 ();

    assign if0.ce = ce;       assign if1.ce = ce;
    assign if0.din0 = din0;   assign if1.din0 = din0;
    assign if0.din1 = din1;   assign if1.din1 = din1;
    assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
    assign if0.clr_ovf = clr_ovf;   assign if1.clr_ovf = clr_ovf;

    bgd_mul_fxp_pipe u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    bgd_mul_fxp_pipe #(.ROUND(0), .SATURATE(0)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact product, optional +half LSB, floor division by 2^FRAC, then clamp or wrap
    function automatic void ref_mul(input int a, input int b, input bit rnd, input bit sat,
                                    output int d, output bit o);
        longint p;
        longint w;
        p = longint'(a) * longint'(b);
        if (rnd) p = p + (longint'(1) << (FRAC - 1));
        p = p >>> FRAC;
        o = (p > PMAX) || (p < PMIN);
        if (sat) begin
            if (p > PMAX)      d = PMAX;
            else if (p < PMIN) d = PMIN;
            else               d = int'(p);
        end else begin
            w = p & ((longint'(1) << PWID) - 1);
            if (w > PMAX) w = w - (longint'(1) << PWID);
            d = int'(w);
        end
    endfunction

    task automatic cyc(input bit v, input int a, input int b, input bit c, input bit clr);
        exp_t e;
        @(negedge clk);
        ce = c; in_valid = v; clr_ovf = clr;
        din0 = 13'(a); din1 = 13'(b);
        if (c && v) begin
            e.idx = ce_edges;
            ref_mul(a, b, 1'b1, 1'b1, e.d0, e.o0);
            ref_mul(a, b, 1'b0, 1'b0, e.d1, e.o1);
            sb.push_back(e);
        end
    endtask

    function automatic int rnd_op();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 200)) - 100;
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    // Monitor: new output only on ce edges; outputs must hold otherwise
    always @(posedge clk) begin
        bit ce_s, clr_s, rst_s;
        int eidx;
        exp_t e;
        ce_s = ce; clr_s = clr_ovf; rst_s = reset;
        #1;
        if (rst_s) begin
            if (ce_s) begin
                eidx = ce_edges;
                ce_edges++;
                chk("valid_pair", int'(if1.out_valid), int'(if0.out_valid));
                if (if0.out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", eidx, e.idx + NS - 1);
                        chk("dout_sat", int'($signed(if0.dout)), e.d0);
                        chk("ovf_sat", int'(if0.ovf), int'(e.o0));
                        chk("dout_wrap", int'($signed(if1.dout)), e.d1);
                        chk("ovf_wrap", int'(if1.ovf), int'(e.o1));
                        if (e.o0 && cnt0_m < 65535) cnt0_m++;
                        if (e.o1 && cnt1_m < 65535) cnt1_m++;
                    end
                end else begin
                    chk("ovf_unqual_sat", int'(if0.ovf), 0);
                    chk("ovf_unqual_wrap", int'(if1.ovf), 0);
                end
            end else begin
                chk("hold_valid", int'(if0.out_valid), int'(prev_v));
                chk("hold_dout_sat", int'($signed(if0.dout)), prev_d0);
                chk("hold_dout_wrap", int'($signed(if1.dout)), prev_d1);
                chk("hold_ovf_sat", int'(if0.ovf), int'(prev_o0));
                chk("hold_ovf_wrap", int'(if1.ovf), int'(prev_o1));
            end
            if (clr_s) begin
                cnt0_m = 0;
                cnt1_m = 0;
            end
            chk("ovf_cnt_sat", int'(if0.ovf_cnt), cnt0_m);
            chk("ovf_cnt_wrap", int'(if1.ovf_cnt), cnt1_m);
            prev_v  = if0.out_valid;
            prev_d0 = int'($signed(if0.dout));
            prev_d1 = int'($signed(if1.dout));
            prev_o0 = if0.ovf;
            prev_o1 = if1.ovf;
        end
    end

    task automatic model_reset();
        sb.delete();
        cnt0_m = 0; cnt1_m = 0;
        prev_v = 0; prev_d0 = 0; prev_d1 = 0; prev_o0 = 0; prev_o1 = 0;
    endtask

    initial begin
        reset = 1'b0; ce = 1'b0; in_valid = 1'b0; clr_ovf = 1'b0;
        din0 = '0; din1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", int'(if0.dout), 0);
        chk("rst_valid", int'(if0.out_valid), 0);
        chk("rst_ovf", int'(if0.ovf), 0);
        chk("rst_cnt", int'(if0.ovf_cnt), 0);
        model_reset();
        reset = 1'b1;

        // Unity-scale product, then rounding of a negative and truncation of a negative
        cyc(1, 64, 64, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0);
        cyc(1, 100, -50, 1, 0);
        cyc(1, 100, -49, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0);

        // Positive and negative overflow
        cyc(1, 4095, 4095, 1, 0);
        cyc(1, -4096, 4095, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0);
        chk("cnt_after_two_ovf", int'(if0.ovf_cnt), 2);

        // Stream of 10 samples with ce toggling every cycle
        for (int i = 0; i < 20; i++) cyc(1, rnd_op(), rnd_op(), (i % 2) == 0, 0);
        repeat (6) cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, rnd_op(), rnd_op(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        repeat (6) cyc(0, 0, 0, 1, 0);

        // Asynchronous reset mid-stream while results and counts are live
        for (int i = 0; i < 6; i++) cyc(1, 4095, -4096, 1, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", int'(if0.out_valid), 0);
        chk("async_rst_dout", int'(if0.dout), 0);
        chk("async_rst_cnt", int'(if0.ovf_cnt), 0);
        chk("async_rst_cnt_wrap", int'(if1.ovf_cnt), 0);
        model_reset();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (8) cyc(0, 0, 0, 1, 0);

        // Clear collides with the sixth overflowed output
        for (int i = 0; i < 6; i++) cyc(1, 4095, 4095, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("cnt_before_clr", int'(if0.ovf_cnt), 5);
        cyc(0, 0, 0, 1, 0);
        chk("cnt_clr_priority", int'(if0.ovf_cnt), 0);
        chk("clr_edge_ovf", int'(if0.ovf), 1);
        repeat (4) cyc(0, 0, 0, 1, 0);

        // Counter saturation
        for (int i = 0; i < 65540; i++) cyc(1, 4095, 4095, 1, 0);
        repeat (8) cyc(0, 0, 0, 1, 0);
        chk("cnt_sat_max", int'(if0.ovf_cnt), 65535);
        chk("cnt_sat_max_wrap", int'(if1.ovf_cnt), 65535);

        repeat (10) cyc(0, 0, 0, 1, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
